frame_writer: RTL and testbench
===============================

# frame_writer

Producer side of the ping-pong frame buffer. Accepts a raster-ordered pixel stream from the game renderer over a valid/ready handshake. Generates the linear write address and data for the back buffer at 320x240, 8-bit colour, one pixel per clock. Synchronises each frame to the buffer-swap pulse and can optionally clear the back buffer to a background colour before drawing.

## Interface
Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- ADDR_W, 20, write address width
- DATA_W, 8, pixel width
- BG_COLOR, 8'h00, colour written during clear

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at buffer swap (scanout at h=0, v=0)
- clear_en  in  1  sampled on frame_start; 1 = clear before drawing
- pix_valid  in  1  renderer has a pixel
- pix_data  in  DATA_W  pixel colour
- pix_ready  out  1  writer accepts pixel this cycle
- addrWrite  out  ADDR_W  back-buffer write address
- dataWrite  out  DATA_W  back-buffer write data
- wr_en  out  1  addrWrite/dataWrite carry a new write this cycle
- busy  out  1  high in CLEAR or DRAW
- frame_done  out  1  one-cycle pulse when the last pixel has been written
- overrun  out  1  one-cycle pulse when frame_start aborts an unfinished frame

## Operation
- States: IDLE, CLEAR, DRAW, DONE.
- IDLE or DONE with frame_start: go to CLEAR if clear_en=1, else DRAW. The address counter resets to 0.
- CLEAR:
  - Writes BG_COLOR to one address per cycle, covering 0..H_RES*V_RES-1 (0..76799).
  - pix_ready=0.
  - After address 76799, go to DRAW with the counter at 0.
- DRAW:
  - pix_ready=1. A pixel is accepted when pix_valid && pix_ready.
  - Each accepted pixel is written to the current address, then the address increments.
  - Pixels are in raster order. addr = y*H_RES + x, kept as an incremental linear counter with no multiplier.
  - Acceptance of pixel 76799 raises frame_done next cycle and moves the state to DONE.
- DONE: pix_ready=0. Outputs hold until the next frame_start.
- The back buffer's write enable is permanently active, so addrWrite/dataWrite must always present a harmless write:
  - when no new write occurs, both hold their last values (an idempotent rewrite);
  - wr_en=0 in that case.
- frame_start while in CLEAR or DRAW:
  - overrun pulses;
  - the current frame is abandoned;
  - the new frame restarts at address 0, with clear_en re-sampled.
- frame_start in the same cycle as acceptance of pixel 76799: the pixel is written, frame_done pulses, and the new frame starts. No overrun.
- Address counter width is ADDR_W. It never exceeds 76799 and never wraps within a frame.

## Timing
- Reset values:
  - state IDLE
  - addrWrite=0, dataWrite=0
  - wr_en=0, pix_ready=0, busy=0
  - frame_done=0, overrun=0
- All outputs are registered except pix_ready, which is decoded from state.
- Latency: a pixel accepted at edge N appears on addrWrite/dataWrite/wr_en after edge N+1.
- frame_start at edge N:
  - busy=1 and the first write (addr 0) appear after edge N+1;
  - in DRAW, pix_ready=1 from the cycle after edge N.
- Clear duration is 76800 cycles. The first DRAW acceptance is possible in the cycle after the address-76799 clear write is issued.
- frame_done and overrun are exactly one cycle wide.
- Reset asserted mid-frame: everything returns to reset values immediately. No frame_done.

## Structure
- Shared package flappy_pkg holds:
  - H_RES, V_RES, FRAME_PIXELS (76800), ADDR_W, DATA_W;
  - the writer_state_t enum.
- Sub-module raster_counter:
  - linear address counter with load-zero, increment and last-pixel flag;
  - reusable later for scanout.
- The top module holds the FSM and the output registers.

## Test plan
- Reset, then frame_start with clear_en=0, then stream 76800 pixels with pix_data = addr[7:0] and pix_valid always 1 -> addrWrite walks 0..76799 with dataWrite = addr[7:0] one cycle after acceptance; frame_done pulses once; state ends in DONE.
- frame_start with clear_en=1 -> 76800 cycles of dataWrite=8'h00 with pix_ready=0, then DRAW; pixel 8'hA5 lands at addr 0.
- Random pix_valid gaps of 0-5 cycles -> addrWrite/dataWrite hold during gaps with wr_en=0; no address skipped or repeated.
- frame_start after 1000 pixels -> overrun pulses; the next accepted pixel is written at addr 0; no frame_done for the aborted frame.
- frame_start coincident with acceptance of pixel 76799 -> frame_done=1, overrun=0, new frame begins at addr 0.
- rst_n low at pixel 500 -> all outputs return to reset values asynchronously; after release, state is IDLE and nothing is written until frame_start.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants and types for the frame buffer producer/consumer blocks.
// Raster geometry defaults to 320x240 at 8 bits per pixel.
package flappy_pkg;

  localparam int H_RES        = 320;
  localparam int V_RES        = 240;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  localparam int ADDR_W       = 20;
  localparam int DATA_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

  // First working state of a new frame, chosen by the sampled clear request.
  function automatic writer_state_t startState(input logic clearReq);
    startState = clearReq ? CLEAR : DRAW;
  endfunction

endpackage

// File: rtl/frame_writer_raster_counter.sv
// Linear raster address counter with load-zero, increment and last-pixel flag.
// Kept generic so the scanout side can reuse it.
module raster_counter #(
  parameter int CNT_W    = flappy_pkg::ADDR_W,
  parameter int LAST_IDX = flappy_pkg::FRAME_PIXELS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadZero,
  input  logic             inc,
  output logic [CNT_W-1:0] addr,
  output logic             isLast
);

  logic [CNT_W-1:0] addr_r;

  // Address register; load-zero wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {CNT_W{1'b0}};
    end else if (loadZero) begin
      addr_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      addr_r <= addr_r + CNT_W'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr   = addr_r;
  assign isLast = (addr_r == CNT_W'(LAST_IDX));

endmodule

// File: rtl/frame_writer.sv
// Back-buffer producer: optional background clear, then raster-ordered pixel
// writes from the renderer, synchronised to the buffer-swap pulse.
module frame_writer #(
  parameter int                H_RES    = flappy_pkg::H_RES,
  parameter int                V_RES    = flappy_pkg::V_RES,
  parameter int                ADDR_W   = flappy_pkg::ADDR_W,
  parameter int                DATA_W   = flappy_pkg::DATA_W,
  parameter logic [DATA_W-1:0] BG_COLOR = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              clear_en,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] addrWrite,
  output logic [DATA_W-1:0] dataWrite,
  output logic              wr_en,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  import flappy_pkg::*;

  localparam int FRAME_PIX = H_RES * V_RES;

  writer_state_t     state_r;
  writer_state_t     nextState_s;
  logic              loadZero_s;
  logic              inc_s;
  logic              isLast_s;
  logic [ADDR_W-1:0] cntAddr_s;
  logic              accept_s;
  logic              wrEn_s;
  logic [ADDR_W-1:0] wrAddr_s;
  logic [DATA_W-1:0] wrData_s;
  logic              frameDone_s;
  logic              overrun_s;

  raster_counter #(
    .CNT_W    (ADDR_W),
    .LAST_IDX (FRAME_PIX - 1)
  ) uCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .loadZero (loadZero_s),
    .inc      (inc_s),
    .addr     (cntAddr_s),
    .isLast   (isLast_s)
  );

  assign pix_ready = (state_r == DRAW);
  assign accept_s  = pix_valid && pix_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state, counter control and next write; idle cycles re-present the last write.
  always_comb begin
    nextState_s = state_r;
    loadZero_s  = 1'b0;
    inc_s       = 1'b0;
    wrEn_s      = 1'b0;
    wrAddr_s    = addrWrite;
    wrData_s    = dataWrite;
    frameDone_s = 1'b0;
    overrun_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (frame_start) begin
          nextState_s = startState(clear_en);
          loadZero_s  = 1'b1;
        end else begin
          nextState_s = state_r;
        end
      end
      CLEAR: begin
        if (frame_start) begin
          overrun_s   = 1'b1;
          nextState_s = startState(clear_en);
          loadZero_s  = 1'b1;
        end else begin
          wrEn_s   = 1'b1;
          wrAddr_s = cntAddr_s;
          wrData_s = BG_COLOR;
          if (isLast_s) begin
            nextState_s = DRAW;
            loadZero_s  = 1'b1;
          end else begin
            inc_s = 1'b1;
          end
        end
      end
      DRAW: begin
        if (accept_s && isLast_s) begin
          // Completing the frame takes priority; a coincident swap just starts the next one.
          wrEn_s      = 1'b1;
          wrAddr_s    = cntAddr_s;
          wrData_s    = pix_data;
          frameDone_s = 1'b1;
          loadZero_s  = 1'b1;
          nextState_s = frame_start ? startState(clear_en) : DONE;
        end else if (frame_start) begin
          overrun_s   = 1'b1;
          nextState_s = startState(clear_en);
          loadZero_s  = 1'b1;
        end else if (accept_s) begin
          wrEn_s   = 1'b1;
          wrAddr_s = cntAddr_s;
          wrData_s = pix_data;
          inc_s    = 1'b1;
        end else begin
          nextState_s = DRAW;
        end
      end
      default: begin
        nextState_s = IDLE;
        loadZero_s  = 1'b1;
      end
    endcase
  end

  // Registered write port and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrWrite  <= {ADDR_W{1'b0}};
      dataWrite  <= {DATA_W{1'b0}};
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      addrWrite  <= wrAddr_s;
      dataWrite  <= wrData_s;
      wr_en      <= wrEn_s;
      busy       <= (state_r == CLEAR) || (state_r == DRAW);
      frame_done <= frameDone_s;
      overrun    <= overrun_s;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a reduced 20x15 raster (300 pixels).
module tb_frame_writer;

  localparam int NPIX = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        clear_en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_ready;
  logic [19:0] addrWrite;
  logic [7:0]  dataWrite;
  logic        wr_en, busy, frame_done, overrun;

  int nVec = 0;
  int nErr = 0;

  frame_writer #(
    .H_RES(20), .V_RES(15), .ADDR_W(20), .DATA_W(8), .BG_COLOR(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .clear_en(clear_en),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .addrWrite(addrWrite), .dataWrite(dataWrite), .wr_en(wr_en), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fs, ce, pv;
    logic [7:0] pd;
    logic       rdy;
    logic [19:0] a;
    logic [7:0] d;
    logic       w, b, fd, ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkOut(input string tag, input logic [19:0] a, input logic [7:0] d,
                        input logic w, input logic b, input logic fd, input logic ov);
    chk({tag, ".addr"}, addrWrite, a);
    chk({tag, ".data"}, dataWrite, d);
    chk({tag, ".wr_en"}, wr_en, w);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".frame_done"}, frame_done, fd);
    chk({tag, ".overrun"}, overrun, ov);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expA;
    int cyc;
    int gap;
    logic [19:0] lastA;
    logic [7:0]  lastD;

    //            fs    ce    pv    pd     rdy   addr    data   wr    busy  done  ovr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 20'd0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 20'd0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 20'd1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 20'd2, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 20'd2, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 20'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 20'd1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    chkOut("rst", 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.pix_ready", pix_ready, 1'b0);
    rst_n = 1'b1;

    // Start, gap, overrun abort with clear request, start of clear
    for (int i = 0; i < 9; i++) begin
      frame_start = tbl[i].fs;
      clear_en    = tbl[i].ce;
      pix_valid   = tbl[i].pv;
      pix_data    = tbl[i].pd;
      chk($sformatf("vec%0d.pix_ready", i), pix_ready, tbl[i].rdy);
      tick();
      chkOut($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].fd, tbl[i].ov);
    end

    // Remainder of the background clear
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    for (int k = 2; k < NPIX; k++) begin
      chk("clear.pix_ready", pix_ready, 1'b0);
      tick();
      chkOut($sformatf("clear%0d", k), k[19:0], 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Draw a full frame with random valid gaps; first pixel is A5
    expA  = 0;
    cyc   = 0;
    lastA = 20'd299;
    lastD = 8'h00;
    while (expA < NPIX && cyc < 5000) begin
      gap = int'($urandom_range(5, 0));
      for (int g = 0; g < gap; g++) begin
        pix_valid = 1'b0;
        pix_data  = 8'hEE;
        tick();
        cyc++;
        chkOut("gap", lastA, lastD, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      pix_valid = 1'b1;
      pix_data  = (expA == 0) ? 8'hA5 : expA[7:0];
      chk("draw.pix_ready", pix_ready, 1'b1);
      tick();
      cyc++;
      chkOut($sformatf("draw%0d", expA), expA[19:0], pix_data, 1'b1, 1'b1,
             (expA == NPIX - 1), 1'b0);
      lastA = expA[19:0];
      lastD = pix_data;
      expA++;
    end
    chk("draw.count", expA, NPIX);

    // DONE: no acceptance, outputs hold
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h33;
      chk("done.pix_ready", pix_ready, 1'b0);
      tick();
      chkOut("done", 20'd299, lastD, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // New frame without clear; swap coincides with the last pixel
    pix_valid   = 1'b0;
    frame_start = 1'b1;
    clear_en    = 1'b0;
    tick();
    frame_start = 1'b0;
    chk("restart.pix_ready", pix_ready, 1'b1);
    chkOut("restart", 20'd299, lastD, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) begin
      pix_valid   = 1'b1;
      pix_data    = p[7:0] ^ 8'h5C;
      frame_start = (p == NPIX - 1);
      tick();
      chkOut($sformatf("coin%0d", p), p[19:0], p[7:0] ^ 8'h5C, 1'b1, 1'b1,
             (p == NPIX - 1), 1'b0);
    end
    frame_start = 1'b0;
    pix_data    = 8'h42;
    chk("coin.next.pix_ready", pix_ready, 1'b1);
    tick();
    chkOut("coin.next", 20'd0, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame
    for (int p = 1; p < 100; p++) begin
      pix_data = p[7:0] ^ 8'hE0;
      tick();
      chkOut("pre_rst", p[19:0], p[7:0] ^ 8'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chkOut("async_rst", 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.pix_ready", pix_ready, 1'b0);
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chkOut("post_rst", 20'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst.pix_ready", pix_ready, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
